// File: rtl/pc_gen.sv
// Instruction-fetch PC generator: drives the instruction-ROM address and chip enable.
// Handles stall hold, branch redirect, flush redirect and a one-entry buffer for stalled branches.
module pc_gen #(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    RESET_VEC  = '0,
    parameter int unsigned          INST_BYTES = 4,
    parameter int unsigned          STALL_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic                branch_flag_i,
    input  logic [ADDR_W-1:0]   branch_target_i,
    input  logic                flush_i,
    input  logic [ADDR_W-1:0]   new_pc_i,
    output logic [ADDR_W-1:0]   pc,
    output logic                ce,
    output logic                redirect_pending_o,
    output logic                misalign_o,
    output logic                state_dbg
);

    typedef enum logic {
        WAKE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Low-bit mask of INST_BYTES; all-zero when INST_BYTES == 1, so misalign stays 0.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] INC        = ADDR_W'(INST_BYTES);
    localparam logic              RESET_MIS  = |(RESET_VEC & ALIGN_MASK);

    state_t             state, next_state;
    logic [ADDR_W-1:0]  pend_tgt, next_tgt;
    logic               pending, next_pending;
    logic [ADDR_W-1:0]  next_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAKE;
            pc         <= RESET_VEC;
            pending    <= 1'b0;
            pend_tgt   <= '0;
            misalign_o <= RESET_MIS;
        end else begin
            state      <= next_state;
            pc         <= next_pc;
            pending    <= next_pending;
            pend_tgt   <= next_tgt;
            misalign_o <= |(next_pc & ALIGN_MASK);
        end
    end

    // Address inputs are only routed through when their flag is set, so X on them stays contained.
    always_comb begin
        next_state   = state;
        next_pc      = pc;
        next_pending = pending;
        next_tgt     = pend_tgt;
        case (state)
            WAKE: begin
                next_state = RUN;
            end
            RUN: begin
                if (flush_i) begin
                    next_pc      = new_pc_i;
                    next_pending = 1'b0;
                end else if (stall[0]) begin
                    if (branch_flag_i) begin
                        next_tgt     = branch_target_i;
                        next_pending = 1'b1;
                    end
                end else if (branch_flag_i) begin
                    next_pc      = branch_target_i;
                    next_pending = 1'b0;
                end else if (pending) begin
                    next_pc      = pend_tgt;
                    next_pending = 1'b0;
                end else begin
                    next_pc = pc + INC;
                end
            end
            default: begin
                next_state = WAKE;
            end
        endcase
    end

    assign ce                 = (state == RUN);
    assign redirect_pending_o = pending;
    assign state_dbg          = state;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: table of per-cycle vectors plus a hand-written async-reset sequence.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'hBFC0_0000;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic [31:0] pc;
    logic        ce;
    logic        redirect_pending_o;
    logic        misalign_o;
    logic        state_dbg;

    int n_assert;
    int n_fail;

    pc_gen #(
        .ADDR_W    (32),
        .RESET_VEC (RV),
        .INST_BYTES(4),
        .STALL_W   (6)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .branch_flag_i     (branch_flag_i),
        .branch_target_i   (branch_target_i),
        .flush_i           (flush_i),
        .new_pc_i          (new_pc_i),
        .pc                (pc),
        .ce                (ce),
        .redirect_pending_o(redirect_pending_o),
        .misalign_o        (misalign_o),
        .state_dbg         (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        br;
        logic [31:0] tgt;
        logic        fl;
        logic [31:0] npc;
        logic [31:0] e_pc;
        logic        e_pend;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [5:0] st, logic br, logic [31:0] tgt,
                                logic fl, logic [31:0] npc, logic [31:0] e_pc,
                                logic e_pend, logic e_mis);
        vec_t v;
        v.name = name; v.stall = st; v.br = br; v.tgt = tgt; v.fl = fl; v.npc = npc;
        v.e_pc = e_pc; v.e_pend = e_pend; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(logic [5:0] st, logic br, logic [31:0] tgt, logic fl, logic [31:0] npc);
        stall           = st;
        branch_flag_i   = br;
        branch_target_i = tgt;
        flush_i         = fl;
        new_pc_i        = npc;
    endtask

    task automatic check_out(string name, logic [31:0] e_pc, logic e_ce, logic e_pend, logic e_mis);
        chk({name, ".pc"},   pc, e_pc);
        chk({name, ".ce"},   {31'd0, ce}, {31'd0, e_ce});
        chk({name, ".pend"}, {31'd0, redirect_pending_o}, {31'd0, e_pend});
        chk({name, ".mis"},  {31'd0, misalign_o}, {31'd0, e_mis});
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(6'h00, 1'b0, 32'h0, 1'b0, 32'h0);

        // Wake cycle: flush is offered but must be ignored.
        vecs.push_back(mk("wake",       6'h00, 0, 32'h0,        1, 32'h40,  RV,            0, 0));
        vecs.push_back(mk("seq1",       6'h00, 0, 32'h0,        0, 32'h0,   RV + 32'h4,    0, 0));
        vecs.push_back(mk("seq2",       6'h00, 0, 32'h0,        0, 32'h0,   RV + 32'h8,    0, 0));
        vecs.push_back(mk("br10",       6'h00, 1, 32'h10,       0, 32'h0,   32'h10,        0, 0));
        vecs.push_back(mk("stall_a",    6'h01, 0, 32'h0,        0, 32'h0,   32'h10,        0, 0));
        vecs.push_back(mk("stall_b",    6'h01, 0, 32'hDEAD,     0, 32'h0,   32'h10,        0, 0));
        vecs.push_back(mk("stall_c",    6'h01, 0, 32'h0,        0, 32'h0,   32'h10,        0, 0));
        vecs.push_back(mk("unstall",    6'h3E, 0, 32'h0,        0, 32'h0,   32'h14,        0, 0));
        vecs.push_back(mk("br20",       6'h00, 1, 32'h20,       0, 32'h0,   32'h20,        0, 0));
        vecs.push_back(mk("sbr100",     6'h01, 1, 32'h100,      0, 32'h0,   32'h20,        1, 0));
        vecs.push_back(mk("sbr200",     6'h01, 1, 32'h200,      0, 32'h0,   32'h20,        1, 0));
        vecs.push_back(mk("pend_go",    6'h00, 0, 32'h0,        0, 32'h0,   32'h200,       0, 0));
        vecs.push_back(mk("seq204",     6'h00, 0, 32'h0,        0, 32'h0,   32'h204,       0, 0));
        vecs.push_back(mk("sbr300",     6'h01, 1, 32'h300,      0, 32'h0,   32'h204,       1, 0));
        vecs.push_back(mk("flush180",   6'h01, 1, 32'h400,      1, 32'h180, 32'h180,       0, 0));
        vecs.push_back(mk("seq184",     6'h00, 0, 32'h0,        0, 32'h0,   32'h184,       0, 0));
        vecs.push_back(mk("sbr500",     6'h01, 1, 32'h500,      0, 32'h0,   32'h184,       1, 0));
        vecs.push_back(mk("live600",    6'h00, 1, 32'h600,      0, 32'h0,   32'h600,       0, 0));
        vecs.push_back(mk("seq604",     6'h00, 0, 32'h0,        0, 32'h0,   32'h604,       0, 0));
        vecs.push_back(mk("brtop",      6'h00, 1, 32'hFFFF_FFFC,0, 32'h0,   32'hFFFF_FFFC, 0, 0));
        vecs.push_back(mk("wrap",       6'h00, 0, 32'h0,        0, 32'h0,   32'h0,         0, 0));
        vecs.push_back(mk("br102",      6'h00, 1, 32'h102,      0, 32'h0,   32'h102,       0, 1));
        vecs.push_back(mk("seq106",     6'h00, 0, 32'h0,        0, 32'h0,   32'h106,       0, 1));
        vecs.push_back(mk("flush8",     6'h00, 0, 32'h0,        1, 32'h8,   32'h8,         0, 0));
        vecs.push_back(mk("sbr700",     6'h01, 1, 32'h700,      0, 32'h0,   32'h8,         1, 0));

        // Reset state, checked while rst is still high across edges.
        @(posedge clk); #1;
        check_out("reset", RV, 1'b0, 1'b0, 1'b0);
        chk("reset.state", {31'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].fl, vecs[i].npc);
            @(posedge clk); #1;
            check_out(vecs[i].name, vecs[i].e_pc, 1'b1, vecs[i].e_pend, vecs[i].e_mis);
        end
        chk("run.state", {31'd0, state_dbg}, 32'd1);

        // Async reset between edges, with a branch still pending.
        drive(6'h00, 1'b0, 32'h0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", RV, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_out("rewake", RV, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_out("reseq", RV + 32'h4, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded 20000 time units");
        $fatal(1, "timeout");
    end

endmodule
